// File: rtl/key_conditioner_if.sv
// Switch-conditioning bundle: raw board inputs in, debounced levels, pulses,
// decoded note and the shared 1 ms tick out.
interface key_conditioner_if #(
  parameter int NOTE_KEY_BITS = 7,
  parameter int BTN_BITS      = 4
);
  logic [NOTE_KEY_BITS-1:0] note_raw;
  logic [BTN_BITS-1:0]      btn_raw;

  logic [NOTE_KEY_BITS-1:0] note_key;
  logic [2:0]               note_code;
  logic                     note_valid;
  logic                     multi_key;
  logic [BTN_BITS-1:0]      btn_level;
  logic [BTN_BITS-1:0]      btn_pulse;
  logic                     ms_tick;

  // master = the conditioner; slave = board side driving raw inputs and
  // the downstream controller consuming the clean outputs.
  modport master (
    input  note_raw, btn_raw,
    output note_key, note_code, note_valid, multi_key,
           btn_level, btn_pulse, ms_tick
  );

  modport slave (
    output note_raw, btn_raw,
    input  note_key, note_code, note_valid, multi_key,
           btn_level, btn_pulse, ms_tick
  );
endinterface

// File: rtl/key_conditioner.sv
// Synchronises and debounces note keys and buttons, decodes a one-hot note,
// produces button edge pulses and a free-running 1 ms tick.
module key_conditioner #(
  parameter int NOTE_KEY_BITS  = 7,
  parameter int BTN_BITS       = 4,
  parameter int TICK_CYCLES    = 100000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int CNT_BITS       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  key_conditioner_if.master  kc
);

  localparam int IN_BITS = NOTE_KEY_BITS + BTN_BITS;
  localparam int TICK_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int POP_W   = $clog2(NOTE_KEY_BITS + 1);

  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] DB_LAST   = CNT_BITS'(DEBOUNCE_TICKS - 1);

  logic [IN_BITS-1:0]  raw_all;
  logic [IN_BITS-1:0]  sync1;
  logic [IN_BITS-1:0]  sync2;
  logic [IN_BITS-1:0]  stable;
  logic [CNT_BITS-1:0] db_cnt [IN_BITS];

  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;

  logic [NOTE_KEY_BITS-1:0] stable_note;
  logic [BTN_BITS-1:0]      stable_btn;

  logic [POP_W-1:0] note_ones;
  logic [2:0]       note_idx_code;
  logic             note_single;
  logic             note_multi;

  logic [NOTE_KEY_BITS-1:0] note_key_q;
  logic [2:0]               note_code_q;
  logic                     note_valid_q;
  logic                     multi_key_q;
  logic [BTN_BITS-1:0]      btn_level_q;
  logic [BTN_BITS-1:0]      btn_pulse_q;

  assign raw_all     = {kc.btn_raw, kc.note_raw};
  assign stable_note = stable[NOTE_KEY_BITS-1:0];
  assign stable_btn  = stable[IN_BITS-1:NOTE_KEY_BITS];

  // Two-flop synchroniser; sync2 is the only stage the logic may look at.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_all;
      sync2 <= sync1;
    end
  end

  // Free-running millisecond tick, phase-aligned to reset release.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A mismatch must survive DEBOUNCE_TICKS ticks; any return to the stable
  // value throws the partial count away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= '0;
      // NOTE: db_cnt is a small flop array, not a RAM, so clearing every entry
      // in reset is cheap and keeps an abandoned count from leaking through.
      for (int i = 0; i < IN_BITS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < IN_BITS; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (tick) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: blocking assignments in always_comb build combinational temporaries,
  // and every output is given a default first so no latch can be inferred.
  always_comb begin
    note_ones     = '0;
    note_idx_code = '0;
    for (int i = 0; i < NOTE_KEY_BITS; i++) begin
      if (stable_note[i]) begin
        note_ones     = note_ones + 1'b1;
        note_idx_code = 3'(i + 1);
      end
    end
    note_single = (note_ones == POP_W'(1));
    note_multi  = (note_ones >  POP_W'(1));
  end

  // Output stage; btn_level_q doubles as the previous stable button value,
  // so a pulse and its level rise land on the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      note_key_q   <= '0;
      note_code_q  <= '0;
      note_valid_q <= 1'b0;
      multi_key_q  <= 1'b0;
      btn_level_q  <= '0;
      btn_pulse_q  <= '0;
    end else begin
      note_key_q   <= note_single ? stable_note : '0;
      note_code_q  <= note_single ? note_idx_code : 3'd0;
      note_valid_q <= note_single;
      multi_key_q  <= note_multi;
      btn_level_q  <= stable_btn;
      btn_pulse_q  <= stable_btn & ~btn_level_q;
    end
  end

  assign kc.note_key   = note_key_q;
  assign kc.note_code  = note_code_q;
  assign kc.note_valid = note_valid_q;
  assign kc.multi_key  = multi_key_q;
  assign kc.btn_level  = btn_level_q;
  assign kc.btn_pulse  = btn_pulse_q;
  assign kc.ms_tick    = tick;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: a cycle-level behavioural model pushes
// every expected output change; a negedge monitor pops and compares.
module tb_key_conditioner;

  localparam int NK = 7;
  localparam int NB = 4;
  localparam int NI = NK + NB;
  localparam int TC = 4;
  localparam int DB = 3;

  typedef struct packed {
    logic [NK-1:0] note_key;
    logic [2:0]    note_code;
    logic          note_valid;
    logic          multi_key;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;
    logic          ms_tick;
  } out_t;

  typedef struct {
    int   cyc;
    out_t val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  key_conditioner_if #(.NOTE_KEY_BITS(NK), .BTN_BITS(NB)) ifc ();

  key_conditioner #(
    .NOTE_KEY_BITS (NK),
    .BTN_BITS      (NB),
    .TICK_CYCLES   (TC),
    .DEBOUNCE_TICKS(DB),
    .CNT_BITS      (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kc   (ifc)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  bit [NK-1:0] cur_note = '0;
  bit [NB-1:0] cur_btn  = '0;
  int          step_n   = 0;

  // Reference model state
  bit [NI-1:0] m_s1, m_s2, m_stable;
  int          m_seen [NI];
  int          m_cyc;
  out_t        m_out  = '0;
  out_t        m_prev = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.note_key   = ifc.note_key;
    o.note_code  = ifc.note_code;
    o.note_valid = ifc.note_valid;
    o.multi_key  = ifc.multi_key;
    o.btn_level  = ifc.btn_level;
    o.btn_pulse  = ifc.btn_pulse;
    o.ms_tick    = ifc.ms_tick;
    return o;
  endfunction

  // One clock edge of the behavioural model, applied with the inputs seen at that edge.
  task automatic model_edge(input bit rst_v, input bit [NI-1:0] raw);
    bit          tick;
    bit [NK-1:0] sn;
    bit [NB-1:0] sb;
    int          pop;
    if (!rst_v) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_cyc = 0; m_out = '0;
      foreach (m_seen[i]) m_seen[i] = 0;
    end else begin
      tick = (m_cyc % TC) == TC - 1;
      sn   = m_stable[NK-1:0];
      sb   = m_stable[NI-1:NK];
      m_out.btn_pulse = sb & ~m_out.btn_level;
      m_out.btn_level = sb;
      pop = $countones(sn);
      m_out.note_key   = (pop == 1) ? sn : '0;
      m_out.note_code  = 3'd0;
      if (pop == 1)
        for (int i = 0; i < NK; i++) if (sn[i]) m_out.note_code = 3'(i + 1);
      m_out.note_valid = (pop == 1);
      m_out.multi_key  = (pop >= 2);
      for (int i = 0; i < NI; i++) begin
        if (m_s2[i] == m_stable[i]) m_seen[i] = 0;
        else if (tick) begin
          m_seen[i]++;
          if (m_seen[i] == DB) begin
            m_stable[i] = m_s2[i];
            m_seen[i]   = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_cyc++;
    end
    m_out.ms_tick = rst_v && ((m_cyc % TC) == TC - 1);
  endtask

  task automatic step(input bit rst_v);
    exp_t e;
    rst_n        = rst_v;
    ifc.note_raw = cur_note;
    ifc.btn_raw  = cur_btn;
    @(posedge clk);
    model_edge(rst_v, {cur_btn, cur_note});
    step_n++;
    if (m_out != m_prev) begin
      e.cyc = step_n;
      e.val = m_out;
      exp_q.push_back(e);
      m_prev = m_out;
    end
    #1;
  endtask

  task automatic cyc_step();
    step(1'b1);
  endtask

  task automatic settle(input int n);
    repeat (n) cyc_step();
  endtask

  // Steps `window` cycles holding inputs; reports first level change and pulse count of button b.
  task automatic observe(input int b, input int window, output int first, output int pulses);
    bit l0;
    l0     = ifc.btn_level[b];
    first  = -1;
    pulses = 0;
    for (int k = 1; k <= window; k++) begin
      cyc_step();
      if (ifc.btn_pulse[b]) pulses++;
      if (first < 0 && ifc.btn_level[b] !== l0) first = k;
    end
  endtask

  // Monitor: every change of the DUT outputs must match the next expected event.
  int   mon_n    = 0;
  out_t mon_last = '0;
  out_t mon_cur;
  exp_t mon_e;

  always @(negedge clk) begin
    mon_n++;
    mon_cur = dut_out();
    if (mon_cur !== mon_last) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_change cycle %0d: got %h, expected no change", mon_n, mon_cur);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_cycle", 64'(mon_n), 64'(mon_e.cyc));
        check("event_value", 64'(mon_cur), 64'(mon_e.val));
      end
      mon_last = mon_cur;
    end
  end

  int first, pulses, lvl_changes, first_code, first_pulse, ticks_seen, last_tick, b;
  bit prev_lvl;

  initial begin
    // 1. Reset and tick cadence
    repeat (5) step(1'b0);
    check("reset_outputs", 64'(dut_out()), 64'(0));
    ticks_seen = 0;
    last_tick  = -1;
    for (int k = 1; k <= 4 * TC; k++) begin
      cyc_step();
      if (ifc.ms_tick) begin
        if (last_tick >= 0) check("tick_period", 64'(k - last_tick), 64'(TC));
        last_tick = k;
        ticks_seen++;
      end
    end
    check("tick_count", 64'(ticks_seen), 64'(4));
    settle($urandom_range(0, TC - 1));

    // 2. Button 0 press and release
    cur_btn[0] = 1'b1;
    cyc_step();
    observe(0, 30, first, pulses);
    check_range("t2_rise_latency", first, (DB - 1) * TC + 2, DB * TC + 2);
    check("t2_pulse_count", 64'(pulses), 64'(1));
    check("t2_no_pulse_held", 64'(ifc.btn_pulse[0]), 64'(0));
    cur_btn[0] = 1'b0;
    cyc_step();
    observe(0, 30, first, pulses);
    check_range("t2_fall_latency", first, (DB - 1) * TC + 2, DB * TC + 2);
    check("t2_release_no_pulse", 64'(pulses), 64'(0));

    // 3. Bouncing button 1
    lvl_changes = 0;
    pulses      = 0;
    prev_lvl    = ifc.btn_level[1];
    for (int t = 0; t < 8; t++) begin
      cur_btn[1] = ~cur_btn[1];
      for (int k = 0; k < 5; k++) begin
        cyc_step();
        if (ifc.btn_pulse[1]) pulses++;
        if (ifc.btn_level[1] !== prev_lvl) lvl_changes++;
        prev_lvl = ifc.btn_level[1];
      end
    end
    check("t3_bounce_level_quiet", 64'(lvl_changes), 64'(0));
    check("t3_bounce_pulse_quiet", 64'(pulses), 64'(0));
    cur_btn[1] = 1'b1;
    cyc_step();
    observe(1, 30, first, pulses);
    check_range("t3_final_latency", first, (DB - 1) * TC + 2, DB * TC + 2);
    check("t3_final_pulse", 64'(pulses), 64'(1));

    // 4. Single note, then two notes
    cur_note = 7'b0000100;
    settle(20);
    check("t4_note_key", 64'(ifc.note_key), 64'(7'b0000100));
    check("t4_note_code", 64'(ifc.note_code), 64'(3));
    check("t4_note_valid", 64'(ifc.note_valid), 64'(1));
    check("t4_multi_clear", 64'(ifc.multi_key), 64'(0));
    cur_note = 7'b0100100;
    settle(20);
    check("t4_multi_note_key", 64'(ifc.note_key), 64'(0));
    check("t4_multi_code", 64'(ifc.note_code), 64'(0));
    check("t4_multi_valid", 64'(ifc.note_valid), 64'(0));
    check("t4_multi_key", 64'(ifc.multi_key), 64'(1));

    // 5. Note and submit rising together
    cur_note = '0;
    cur_btn  = '0;
    settle(20);
    cur_note    = 7'b1000000;
    cur_btn     = 4'b0001;
    first_code  = -1;
    first_pulse = -1;
    for (int k = 1; k <= 30; k++) begin
      cyc_step();
      if (first_code < 0 && ifc.note_code == 3'd7) first_code = k;
      if (first_pulse < 0 && ifc.btn_pulse[0]) first_pulse = k;
    end
    check_range("t5_code_seen", first_code, 1, 30);
    check("t5_same_cycle", 64'(first_pulse), 64'(first_code));

    // 6. Reset in the middle of a debounce
    cur_note = '0;
    cur_btn  = '0;
    settle(20);
    cur_btn[2] = 1'b1;
    for (int k = 0; k < 40 && m_seen[NK + 2] != 2; k++) cyc_step();
    check("t6_two_ticks_reached", 64'(m_seen[NK + 2]), 64'(2));
    check("t6_not_yet_accepted", 64'(ifc.btn_level[2]), 64'(0));
    step(1'b0);
    check("t6_outputs_in_reset", 64'(dut_out()), 64'(0));
    observe(2, 25, first, pulses);
    check("t6_rearm_latency", 64'(first), 64'(DB * TC + 1));
    check("t6_rearm_pulse", 64'(pulses), 64'(1));

    // Random phase: sparse bit flips with occasional reset pulses
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom_range(0, NI - 1);
        if (b < NK) cur_note[b] = ~cur_note[b];
        else        cur_btn[b - NK] = ~cur_btn[b - NK];
      end
      if ($urandom_range(0, 249) == 0) step(1'b0);
      else                             cyc_step();
    end
    cur_note = '0;
    cur_btn  = '0;
    settle(30);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Front-end input stage that sits directly upstream of the piano controller.
- Synchronises and debounces the raw board switches: 7 note keys, plus the submit, cancel, octave-up and octave-down buttons.
- Outputs:
  - clean button levels;
  - single-cycle rising-edge pulses;
  - a validated one-hot note vector, which drives the controller's note_key / submit / cancel / oct_up / oct_down inputs.
- Also generates the shared 1 ms tick.

Parameters:
- NOTE_KEY_BITS, 7: number of note switches.
- BTN_BITS, 4: number of buttons. Bit order: 0=submit, 1=cancel, 2=oct_up, 3=oct_down.
- TICK_CYCLES, 100000: clk cycles per ms tick (100 MHz clock).
- DEBOUNCE_TICKS, 20: consecutive ticks an input must differ from its stable value before it is accepted.
- CNT_BITS, 5: width of each debounce counter; must hold DEBOUNCE_TICKS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset (clock is clk, reset is rst_n, sampled on posedge clk).
- note_raw  in  NOTE_KEY_BITS  asynchronous note switches.
- btn_raw  in  BTN_BITS  asynchronous buttons.
- note_key  out  NOTE_KEY_BITS  debounced one-hot note; zero if no key or more than one key is held.
- note_code  out  3  1..7 = index+1 of the single held key; 0 otherwise.
- note_valid  out  1  exactly one debounced note key is held.
- multi_key  out  1  two or more debounced note keys are held.
- btn_level  out  BTN_BITS  debounced button levels.
- btn_pulse  out  BTN_BITS  one-cycle pulse on each debounced 0->1 transition.
- ms_tick  out  1  one-cycle pulse every TICK_CYCLES clocks.

Behaviour:
- Reset (rst_n low at a posedge):
  - all outputs are 0;
  - synchronisers, stable registers, debounce counters and tick counter are cleared;
  - reset asserted mid-debounce abandons the count, with no output glitch afterwards.
- Synchroniser:
  - two flops per raw input (NOTE_KEY_BITS+BTN_BITS bits);
  - "synced" is the second stage.
- Tick generator:
  - tick_cnt counts 0..TICK_CYCLES-1 and wraps to 0;
  - ms_tick=1 in the cycle in which tick_cnt==TICK_CYCLES-1;
  - first tick falls TICK_CYCLES cycles after reset release.
- Per-input debounce (independent for each of the 11 inputs):
  - synced==stable: counter forced to 0 every cycle, including tick cycles. Any bounce back restarts the count.
  - synced!=stable and ms_tick: if counter==DEBOUNCE_TICKS-1, then stable<=synced and counter<=0; else counter+1.
  - synced!=stable and no tick: counter holds.
  - Consequence: a change is accepted on the DEBOUNCE_TICKS-th tick seen while the mismatch persists. Acceptance latency lies in [(DEBOUNCE_TICKS-1)*TICK_CYCLES+2, DEBOUNCE_TICKS*TICK_CYCLES+2] cycles after the raw edge, plus 1 cycle of output register.
- Outputs are registered from the stable values, so they change 1 cycle after stable:
  - btn_level = stable_btn;
  - btn_pulse[i] = stable_btn[i] & ~prev_stable_btn[i]. It is high for exactly 1 cycle and never repeats while held. Release produces no pulse.
- Note decode, from stable_note:
  - popcount 0: note_key=0, code=0, valid=0, multi=0.
  - popcount 1: note_key=stable_note, code=bit index+1, valid=1, multi=0.
  - popcount >=2: note_key=0, code=0, valid=0, multi=1.
- Simultaneous events:
  - inputs are fully independent;
  - several btn_pulse bits may assert in the same cycle, and consumers prioritise;
  - a tick that coincides with acceptance is consumed by that acceptance.
- Counter widths saturate by construction: the counter never exceeds DEBOUNCE_TICKS-1.

Test Plan (TICK_CYCLES=4, DEBOUNCE_TICKS=3):
1. Reset held 5 cycles, then released, raw inputs all 0:
   - all outputs 0;
   - ms_tick pulses on cycles 4, 8, 12, … after release, each 1 cycle wide.
2. btn_raw[0] rises and is held:
   - btn_level[0] rises between 10 and 14 cycles after the raw edge;
   - btn_pulse[0]=1 for exactly that one cycle, and 0 thereafter while held;
   - release gives btn_level[0]=0 after the same latency, with no pulse.
3. btn_raw[1] toggles every 5 cycles for 40 cycles, then stays 1:
   - no btn_level/btn_pulse activity during toggling;
   - a single pulse 10–14 cycles after the final rise.
4. note_raw=7'b0000100 held:
   - note_key=7'b0000100, note_code=3, note_valid=1, multi_key=0.
   - then note_raw=7'b0100100: note_key=0, note_code=0, note_valid=0, multi_key=1.
5. note_raw=7'b1000000 and btn_raw=4'b0001 rise in the same cycle:
   - note_code=7 and btn_pulse[0] appear on the same cycle.
6. rst_n pulled low for 1 cycle while btn_raw[2] is mid-debounce (2 ticks counted):
   - outputs 0;
   - after release, full 3-tick debounce is required again before btn_level[2]=1.
